led_blink_scheduler: RTL
========================

Name: led_blink_scheduler

Overview:
- Shares the single board LED between NUM_REQ requesters; each requester asks for a blink code of N flashes.
- Round-robin arbiter grants one request at a time. An internal step prescaler, same reload scheme as the clock divider, sequences the ON/OFF/GAP timing.
- The scheduler drives the active-low LED pin directly. It sits at top level between status sources and nLED.

Parameters:
- CLK_FREQ, 12000000, input clock frequency in Hz.
- STEP_HZ, 8, step rate in Hz; step period P = CLK_FREQ/STEP_HZ cycles (integer division); P >= 2 is required, elaboration error otherwise.
- NUM_REQ, 4, number of requesters (>= 2).
- COUNT_W, 4, width of each blink count.
- GAP_STEPS, 4, dark steps appended after a code (>= 1).

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous active-low reset.
- enable  in  1  high = run; low = freeze prescaler and FSM.
- req  in  NUM_REQ  per-requester request, level, held until ack.
- blinkCount  in  NUM_REQ*COUNT_W  packed counts, requester i at [i*COUNT_W +: COUNT_W].
- ack  out  NUM_REQ  one-cycle completion pulse to granted requester.
- busy  out  1  high in any state except IDLE.
- grantId  out  clog2(NUM_REQ)  index currently served; holds last value in IDLE.
- nLED  out  1  LED drive, 0 = lit.

Behaviour:
- Reset (async, nRst=0): state IDLE, nLED=1, ack=0, busy=0, grantId=0, rr pointer=0, prescaler=0, remaining=0.
- Prescaler:
  - counts 0..P-1 while enable=1 and state in ON/OFF/GAP.
  - stepPulse is high for 1 cycle when count=P-1, then count reloads to 0.
  - count clears to 0 on every grant.
- FSM, all outputs registered:
  - IDLE: enable=1 and |req → grant the first requesting index at or after the rr pointer (cyclic). Latch count=blinkCount[g] and grantId=g. count=0 → DONE. Else → ON with remaining=count.
  - ON: nLED=0. On stepPulse → OFF.
  - OFF: nLED=1. On stepPulse: remaining==1 → GAP with gap counter=GAP_STEPS; else remaining-1 → ON.
  - GAP: nLED=1. On stepPulse decrement the gap counter; on reaching 0 → DONE.
  - DONE: ack[grantId]=1 for exactly one cycle, rr pointer=(grantId+1) mod NUM_REQ, → IDLE.
- Latency:
  - Grant sampled at cycle t gives nLED=0 at t+1.
  - For count N>0, ack is high at cycle t+1+(2N+GAP_STEPS)*P, with enable high throughout.
  - For N=0, ack is high at t+1 and nLED stays 1.
- blinkCount is sampled only at grant; later changes are ignored.
- req deasserted mid-sequence: the sequence completes and ack still pulses.
- New requests during busy wait. The earliest re-grant is the cycle after DONE; there is no back-to-back grant in DONE.
- enable=0: prescaler, counters, state and all outputs hold. ack never extends; enable only gates the IDLE grant and the step advance.
- Count=2^COUNT_W-1 is valid; remaining never wraps.
- Reset asserted mid-operation: immediate return to reset values; no ack for the aborted code.

Optional Feature:
- ARB_FIXED_PRIORITY_EN.
- Defined: IDLE grants the lowest-index requester regardless of the rr pointer; the pointer is not maintained.
- Undefined (default): round-robin as above.

Test Plan:
All scenarios use CLK_FREQ=80, STEP_HZ=8 (P=10), NUM_REQ=4, COUNT_W=4, GAP_STEPS=4, enable=1 unless stated.
1. req[1]=1, count=3 at cycle t → nLED low for 10 cycles three times, each separated by 10 high cycles. ack[1] pulses at t+101 and busy falls the next cycle.
2. req[0] and req[2] asserted together after reset, count=1 each → 0 served then 2. Then req[0] and req[3] with pointer=3 → 3 served before 0.
3. req[2]=1, count=0 → ack[2]=1 at t+1 for one cycle; nLED never leaves 1.
4. count=2 with enable=0 for 25 cycles while in ON → nLED held at 0 through the pause; ack delayed to t+1+80+25.
5. nRst low at cycle 15 of count=5 → nLED=1, busy=0, ack=0 immediately; no ack afterwards. After release, a new req[3] is granted normally.
6. count=15 → 15 flashes, ack at t+1+340. With ARB_FIXED_PRIORITY_EN, req[0] and req[1] held continuously → req[0] is re-granted every time.

Source files
------------

// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: shares one active-low board LED between NUM_REQ
// requesters. Each requester asks for a blink code of N flashes. A step
// prescaler (period CLK_FREQ/STEP_HZ cycles) times the ON/OFF/GAP phases.
// Optional build macro: ARB_FIXED_PRIORITY_EN makes the arbiter serve the
// lowest requesting index instead of going round-robin.
module led_blink_scheduler #(
  parameter int CLK_FREQ  = 12000000,
  parameter int STEP_HZ   = 8,
  parameter int NUM_REQ   = 4,
  parameter int COUNT_W   = 4,
  parameter int GAP_STEPS = 4
) (
  input  logic                         clk,
  input  logic                         nRst,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*COUNT_W-1:0]   blinkCount,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grantId,
  output logic                         nLED
);

  localparam int P     = CLK_FREQ / STEP_HZ;
  localparam int PS_W  = (P > 1) ? $clog2(P) : 1;
  localparam int GAP_W = $clog2(GAP_STEPS + 1);
  localparam int ID_W  = $clog2(NUM_REQ);

  generate
    if (P < 2) begin : g_bad_step
      $error("led_blink_scheduler: CLK_FREQ/STEP_HZ must be at least 2");
    end
    if (NUM_REQ < 2) begin : g_bad_req
      $error("led_blink_scheduler: NUM_REQ must be at least 2");
    end
    if (GAP_STEPS < 1) begin : g_bad_gap
      $error("led_blink_scheduler: GAP_STEPS must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state, state_next;
  logic [PS_W-1:0]    presc;
  logic [COUNT_W-1:0] remaining, remaining_next;
  logic [GAP_W-1:0]   gap_cnt, gap_next;
  logic [ID_W-1:0]    grant_next;
  logic [NUM_REQ-1:0] ack_next;
  logic               busy_next;
  logic               nled_next;
  logic               clr_presc;
  logic               active;
  logic               step_pulse;

  logic               pick_found;
  logic [ID_W-1:0]    pick;
  logic [COUNT_W-1:0] pick_cnt;
  int                 arb_base;
  int                 arb_idx;

`ifndef ARB_FIXED_PRIORITY_EN
  logic [ID_W-1:0]    rr_ptr, rr_next;
`endif

  assign active     = (state == S_ON) || (state == S_OFF) || (state == S_GAP);
  assign step_pulse = active && enable && (presc == PS_W'(P - 1));
  assign pick_cnt   = blinkCount[int'(pick)*COUNT_W +: COUNT_W];

  // Arbiter: first requesting index scanning cyclically from the base.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    arb_idx    = 0;
`ifdef ARB_FIXED_PRIORITY_EN
    arb_base   = 0;
`else
    arb_base   = int'(rr_ptr);
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_idx = (arb_base + i) % NUM_REQ;
      if (!pick_found && req[arb_idx]) begin
        pick_found = 1'b1;
        pick       = ID_W'(arb_idx);
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    gap_next       = gap_cnt;
    grant_next     = grantId;
    ack_next       = '0;
    busy_next      = busy;
    nled_next      = nLED;
    clr_presc      = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
    rr_next        = rr_ptr;
`endif
    case (state)
      S_IDLE: begin
        if (enable && pick_found) begin
          grant_next = pick;
          clr_presc  = 1'b1;
          busy_next  = 1'b1;
          if (pick_cnt == '0) begin
            // Empty code: complete immediately, LED stays dark.
            state_next     = S_DONE;
            ack_next[pick] = 1'b1;
            nled_next      = 1'b1;
          end else begin
            state_next     = S_ON;
            remaining_next = pick_cnt;
            nled_next      = 1'b0;
          end
        end
      end
      S_ON: begin
        if (step_pulse) begin
          state_next = S_OFF;
          nled_next  = 1'b1;
        end
      end
      S_OFF: begin
        if (step_pulse) begin
          if (remaining == COUNT_W'(1)) begin
            state_next = S_GAP;
            gap_next   = GAP_W'(GAP_STEPS);
          end else begin
            state_next     = S_ON;
            remaining_next = remaining - 1'b1;
            nled_next      = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (step_pulse) begin
          gap_next = gap_cnt - 1'b1;
          if (gap_cnt == GAP_W'(1)) begin
            // ack is raised on entry to DONE so it lines up with that state.
            state_next        = S_DONE;
            ack_next[grantId] = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
        rr_next    = (grantId == ID_W'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
`endif
      end
      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
        nled_next  = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= S_IDLE;
      remaining <= '0;
      gap_cnt   <= '0;
      grantId   <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      nLED      <= 1'b1;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      gap_cnt   <= gap_next;
      grantId   <= grant_next;
      ack       <= ack_next;
      busy      <= busy_next;
      nLED      <= nled_next;
    end
  end

  // Step prescaler: runs only while a code is being played and enable is high.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      presc <= '0;
    end else if (clr_presc) begin
      presc <= '0;
    end else if (active && enable) begin
      presc <= (presc == PS_W'(P - 1)) ? '0 : presc + 1'b1;
    end
  end

`ifndef ARB_FIXED_PRIORITY_EN
  // Round-robin pointer, advanced past the requester just served.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_next;
    end
  end
`endif

endmodule
